// File: rtl/switch_debounce.sv
// Switch input conditioner: 2-flop synchroniser and per-switch debounce FSM.
// Also produces edge pulses, a sticky W1C change status and a level interrupt.
module switch_debounce #(
  parameter int   NUM_SW          = 4,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [NUM_SW-1:0] sw_in,
  input  logic [NUM_SW-1:0] chg_clr,
  input  logic              irq_en,
  output logic [NUM_SW-1:0] sw_state,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic [NUM_SW-1:0] chg_status,
  output logic              irq,
  output logic [NUM_SW-1:0] dbg_state
);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_COUNT  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] s1_q, s2_q;
  logic [NUM_SW-1:0] state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];
  logic [CNT_W-1:0]  cnt_d [NUM_SW];
  logic [NUM_SW-1:0] sw_state_q, sw_state_d;
  logic [NUM_SW-1:0] rise_q, rise_d;
  logic [NUM_SW-1:0] fall_q, fall_d;
  logic [NUM_SW-1:0] chg_q, chg_d;
  logic              irq_q, irq_d;
  logic [NUM_SW-1:0] accept;

  // cnt holds the number of consecutive edges at which s2 has disagreed with sw_state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sw_state_d = sw_state_q;
    accept     = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      case (state_q[i])
        ST_STABLE: begin
          if (s2_q[i] != sw_state_q[i]) begin
            state_d[i] = ST_COUNT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        default: begin
          if (s2_q[i] == sw_state_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            sw_state_d[i] = s2_q[i];
            accept[i]     = 1'b1;
            cnt_d[i]      = '0;
            state_d[i]    = ST_STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign rise_d = accept & s2_q;
  assign fall_d = accept & ~s2_q;
  // A new event in the same cycle as its clear strobe keeps the bit set.
  assign chg_d  = (chg_q & ~chg_clr) | accept;
  assign irq_d  = irq_en & (|chg_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s1_q       <= {NUM_SW{RESET_LEVEL}};
      s2_q       <= {NUM_SW{RESET_LEVEL}};
      sw_state_q <= {NUM_SW{RESET_LEVEL}};
      state_q    <= {NUM_SW{ST_STABLE}};
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
      rise_q     <= '0;
      fall_q     <= '0;
      chg_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= sw_in;
      s2_q       <= s1_q;
      sw_state_q <= sw_state_d;
      state_q    <= state_d;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      chg_q      <= chg_d;
      irq_q      <= irq_d;
    end
  end

  assign sw_state   = sw_state_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign chg_status = chg_q;
  assign irq        = irq_q;
  assign dbg_state  = state_q;

endmodule
